// File: rtl/temp_scan_ctrl.sv
// Scan scheduler for four temperature sensors: select, settle, convert, capture per enabled channel.
// Optional 4-sample tick averaging per channel is enabled by defining TEMP_SCAN_AVG_EN.
module temp_scan_ctrl #(
  parameter int TIMEOUT = 4095
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        cont_i,
  input  logic [3:0]  chan_en_i,
  input  logic [7:0]  settle_i,
  output logic [1:0]  temp_sel_o,
  output logic        conv_start_o,
  input  logic        conv_done_i,
  input  logic [11:0] temp_ticks_i,
  input  logic [5:0]  temp_dac_i,
  output logic [47:0] ticks_o,
  output logic [23:0] dac_o,
  output logic [3:0]  err_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [11:0] TO_LAST = 12'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, CONV, WAIT, CAPTURE, NEXT} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  sel_reg, sel_next;
  logic [7:0]  settle_cnt_reg, settle_cnt_next;
  logic [11:0] to_cnt_reg, to_cnt_next;
  logic        done_reg, done_next;

  logic        wr_en;
  logic [11:0] wr_ticks;
  logic [5:0]  wr_dac;
  logic        wr_err;

  logic [11:0] ticks_reg [4];
  logic [5:0]  dac_reg [4];
  logic [3:0]  err_reg;

  logic [1:0]  low_idx;
  logic [2:0]  nxt;

`ifdef TEMP_SCAN_AVG_EN
  logic [1:0]  round_reg, round_next;
  logic [13:0] acc_reg, acc_next;
  logic [13:0] acc_sum;

  assign acc_sum = acc_reg + 14'(temp_ticks_i);
`endif

  function automatic logic [1:0] lowest_chan(input logic [3:0] en);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (en[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Returns {found, index} of the next enabled channel above cur.
  function automatic logic [2:0] next_chan(input logic [3:0] en, input logic [1:0] cur);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (en[i] && (i > int'(cur))) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

  assign low_idx = lowest_chan(chan_en_i);
  assign nxt     = next_chan(chan_en_i, sel_reg);

  always_comb begin
    state_next      = state_reg;
    sel_next        = sel_reg;
    settle_cnt_next = settle_cnt_reg;
    to_cnt_next     = to_cnt_reg;
    done_next       = 1'b0;
    wr_en           = 1'b0;
    wr_ticks        = temp_ticks_i;
    wr_dac          = temp_dac_i;
    wr_err          = 1'b0;
`ifdef TEMP_SCAN_AVG_EN
    round_next      = round_reg;
    acc_next        = acc_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          if (chan_en_i != 4'b0000) begin
            sel_next        = low_idx;
            settle_cnt_next = settle_i;
            state_next      = SETTLE;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      SETTLE: begin
`ifdef TEMP_SCAN_AVG_EN
        round_next = 2'd0;
        acc_next   = 14'd0;
`endif
        // A load of 0 or 1 both give a single settle cycle.
        if (settle_cnt_reg <= 8'd1) begin
          state_next = CONV;
        end else begin
          settle_cnt_next = settle_cnt_reg - 8'd1;
        end
      end
      CONV: begin
        to_cnt_next = 12'd0;
        state_next  = WAIT;
      end
      WAIT: begin
        if (conv_done_i) begin
          state_next = CAPTURE;
        end else if (to_cnt_reg == TO_LAST) begin
          wr_en      = 1'b1;
          wr_ticks   = 12'hFFF;
          wr_dac     = 6'h3F;
          wr_err     = 1'b1;
          state_next = NEXT;
        end else begin
          to_cnt_next = to_cnt_reg + 12'd1;
        end
      end
      CAPTURE: begin
`ifdef TEMP_SCAN_AVG_EN
        if (round_reg == 2'd3) begin
          wr_en      = 1'b1;
          wr_ticks   = acc_sum[13:2];
          state_next = NEXT;
        end else begin
          acc_next   = acc_sum;
          round_next = round_reg + 2'd1;
          state_next = CONV;
        end
`else
        wr_en      = 1'b1;
        state_next = NEXT;
`endif
      end
      NEXT: begin
        if (nxt[2]) begin
          sel_next        = nxt[1:0];
          settle_cnt_next = settle_i;
          state_next      = SETTLE;
        end else begin
          done_next = 1'b1;
          if (cont_i && (chan_en_i != 4'b0000)) begin
            sel_next        = low_idx;
            settle_cnt_next = settle_i;
            state_next      = SETTLE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      sel_reg        <= 2'd0;
      settle_cnt_reg <= 8'd0;
      to_cnt_reg     <= 12'd0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      settle_cnt_reg <= settle_cnt_next;
      to_cnt_reg     <= to_cnt_next;
      done_reg       <= done_next;
    end
  end

`ifdef TEMP_SCAN_AVG_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      round_reg <= 2'd0;
      acc_reg   <= 14'd0;
    end else begin
      round_reg <= round_next;
      acc_reg   <= acc_next;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int n = 0; n < 4; n++) begin
        ticks_reg[n] <= 12'd0;
        dac_reg[n]   <= 6'd0;
      end
      err_reg <= 4'd0;
    end else if (wr_en) begin
      ticks_reg[sel_reg] <= wr_ticks;
      dac_reg[sel_reg]   <= wr_dac;
      err_reg[sel_reg]   <= wr_err;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_pack
    assign ticks_o[12*gi +: 12] = ticks_reg[gi];
    assign dac_o[6*gi +: 6]     = dac_reg[gi];
  end

  assign err_o        = err_reg;
  assign temp_sel_o   = sel_reg;
  assign conv_start_o = (state_reg == CONV);
  assign busy_o       = (state_reg != IDLE);
  assign done_o       = done_reg;

endmodule

// File: tb/tb_temp_scan_ctrl.sv
// Scoreboard bench for temp_scan_ctrl: a sensor model answers conversions, expected
// per-scan snapshots and select sequences are queued at start and checked at done_o/conv_start_o.
module tb_temp_scan_ctrl;

  localparam int TO = 16;
`ifdef TEMP_SCAN_AVG_EN
  localparam int NCONV = 4;
`else
  localparam int NCONV = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        cont_i;
  logic [3:0]  chan_en_i;
  logic [7:0]  settle_i;
  logic [1:0]  temp_sel_o;
  logic        conv_start_o;
  logic        conv_done_i;
  logic [11:0] temp_ticks_i;
  logic [5:0]  temp_dac_i;
  logic [47:0] ticks_o;
  logic [23:0] dac_o;
  logic [3:0]  err_o;
  logic        busy_o;
  logic        done_o;

  temp_scan_ctrl #(.TIMEOUT(TO)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .cont_i       (cont_i),
    .chan_en_i    (chan_en_i),
    .settle_i     (settle_i),
    .temp_sel_o   (temp_sel_o),
    .conv_start_o (conv_start_o),
    .conv_done_i  (conv_done_i),
    .temp_ticks_i (temp_ticks_i),
    .temp_dac_i   (temp_dac_i),
    .ticks_o      (ticks_o),
    .dac_o        (dac_o),
    .err_o        (err_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [47:0] ticks;
    logic [23:0] dac;
    logic [3:0]  err;
    logic        busy;
  } snap_t;

  snap_t      sb_q [$];
  logic [1:0] sel_q [$];

  logic [11:0] tick_base [4] = '{12'h123, 12'h0AB, 12'h456, 12'h789};
  logic [5:0]  dac_base [4]  = '{6'h11, 6'h22, 6'h33, 6'h04};

  logic [11:0] m_ticks [4];
  logic [5:0]  m_dac [4];
  logic [3:0]  m_err;
  logic [3:0]  mute;

  int n_compared = 0;
  int n_mismatch = 0;
  int done_cnt   = 0;
  int scan_no    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance the reference model through one scan and queue what the DUT should show at done_o.
  task automatic push_scan(input logic [3:0] en, input logic [3:0] mt, input logic busy_exp);
    int    sum;
    snap_t s;
    for (int c = 0; c < 4; c++) begin
      if (en[c]) begin
        if (mt[c]) begin
          sel_q.push_back(2'(c));
          m_ticks[c] = 12'hFFF;
          m_dac[c]   = 6'h3F;
          m_err[c]   = 1'b1;
        end else begin
          sum = 0;
          for (int r = 0; r < NCONV; r++) begin
            sel_q.push_back(2'(c));
            sum += int'(tick_base[c]) + r;
          end
          m_ticks[c] = 12'(sum / NCONV);
          m_dac[c]   = dac_base[c] + 6'(NCONV - 1);
          m_err[c]   = 1'b0;
        end
      end
    end
    for (int c = 0; c < 4; c++) begin
      s.ticks[12*c +: 12] = m_ticks[c];
      s.dac[6*c +: 6]     = m_dac[c];
    end
    s.err  = m_err;
    s.busy = busy_exp;
    sb_q.push_back(s);
  endtask

  // Sensor model: answers a conversion two cycles after conv_start_o unless muted.
  int         s_cd = 0;
  int         s_round = 0;
  logic [1:0] s_last_sel = 2'd0;
  initial begin
    conv_done_i  = 1'b0;
    temp_ticks_i = 12'd0;
    temp_dac_i   = 6'd0;
    forever begin
      @(negedge clk_i);
      conv_done_i = 1'b0;
      if (rst_i || done_o || (temp_sel_o != s_last_sel)) s_round = 0;
      s_last_sel = temp_sel_o;
      if (rst_i) begin
        s_cd = 0;
      end else begin
        if (s_cd > 0) begin
          s_cd--;
          if (s_cd == 0) begin
            conv_done_i  = 1'b1;
            temp_ticks_i = tick_base[temp_sel_o] + 12'(s_round);
            temp_dac_i   = dac_base[temp_sel_o] + 6'(s_round);
            s_round++;
          end
        end
        if (conv_start_o && !mute[temp_sel_o]) s_cd = 2;
      end
    end
  end

  // Monitor: select order, timeout latency, and result snapshots at each done_o.
  int         mon_cyc = 0;
  logic       to_pending = 1'b0;
  int         to_start = 0;
  logic [1:0] to_sel = 2'd0;
  initial begin
    snap_t      e;
    logic [1:0] es;
    forever begin
      @(negedge clk_i);
      mon_cyc++;
      if (rst_i) begin
        to_pending = 1'b0;
      end else begin
        if (conv_start_o) begin
          if (sel_q.size() == 0) begin
            check("sel_unexp", 64'(sel_q.size()), 64'd1);
          end else begin
            es = sel_q.pop_front();
            check("sel", temp_sel_o, es);
          end
          if (mute[temp_sel_o] && !to_pending) begin
            to_pending = 1'b1;
            to_start   = mon_cyc;
            to_sel     = temp_sel_o;
          end
        end else if (to_pending && (temp_sel_o != to_sel)) begin
          // CONV + TIMEOUT WAIT cycles + NEXT before the select moves on
          check("to_lat", 64'(mon_cyc - to_start), 64'(TO + 2));
          to_pending = 1'b0;
        end
        if (done_o) begin
          done_cnt++;
          to_pending = 1'b0;
          if (sb_q.size() == 0) begin
            check("done_unexp", 64'(sb_q.size()), 64'd1);
          end else begin
            e = sb_q.pop_front();
            scan_no++;
            $display("scan %0d: ticks=%h dac=%h err=%b busy=%b", scan_no, ticks_o, dac_o, err_o, busy_o);
            check("ticks", ticks_o, e.ticks);
            check("dac", dac_o, e.dac);
            check("err", err_o, e.err);
            check("busy_at_done", busy_o, e.busy);
          end
        end
      end
    end
  end

  task automatic run_scan(input logic [3:0] en, input logic [7:0] settle, input logic [3:0] mt,
                          input int nscans);
    int target;
    int cyc;
    chan_en_i = en;
    settle_i  = settle;
    mute      = mt;
    cont_i    = (nscans > 1);
    for (int s = 0; s < nscans; s++) push_scan(en, mt, s != nscans - 1);
    target  = done_cnt + nscans;
    start_i = 1'b1;
    @(negedge clk_i); #1;
    start_i = 1'b0;
    check("busy_rise", busy_o, en != 4'b0000);
    cyc = 0;
    while (done_cnt < target && cyc < 4000) begin
      if (cont_i && done_cnt >= target - 1) cont_i = 1'b0;
      start_i = (cyc == 6) && busy_o;
      @(negedge clk_i); #1;
      cyc++;
    end
    start_i = 1'b0;
    cont_i  = 1'b0;
    check("scan_done", 64'(done_cnt), 64'(target));
    repeat (20) @(negedge clk_i);
    #1;
    check("no_extra_done", 64'(done_cnt), 64'(target));
    check("idle_busy", busy_o, 1'b0);
  endtask

  initial begin
    int cyc;
    rst_i     = 1'b1;
    start_i   = 1'b0;
    cont_i    = 1'b0;
    chan_en_i = 4'b0000;
    settle_i  = 8'd0;
    mute      = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      m_ticks[c] = 12'd0;
      m_dac[c]   = 6'd0;
    end
    m_err = 4'b0000;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_ticks", ticks_o, 48'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_sel", temp_sel_o, 2'd0);
    check("rst_done", done_o, 1'b0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;

    run_scan(4'b0101, 8'd3, 4'b0000, 1);
    run_scan(4'b0111, 8'd2, 4'b0010, 1);
    run_scan(4'b0010, 8'd0, 4'b0000, 1);
    run_scan(4'b1000, 8'd1, 4'b0000, 3);
    run_scan(4'b0000, 8'd4, 4'b0000, 1);

    // Reset while ch1 is waiting on a conversion that never completes.
    chan_en_i = 4'b0010;
    settle_i  = 8'd0;
    mute      = 4'b0010;
    sel_q.push_back(2'd1);
    start_i = 1'b1;
    @(negedge clk_i); #1;
    start_i = 1'b0;
    cyc = 0;
    while (!conv_start_o && cyc < 100) begin
      @(negedge clk_i); #1;
      cyc++;
    end
    check("rst_reach_conv", conv_start_o, 1'b1);
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("arst_ticks", ticks_o, 48'd0);
    check("arst_dac", dac_o, 24'd0);
    check("arst_err", err_o, 4'd0);
    check("arst_busy", busy_o, 1'b0);
    check("arst_sel", temp_sel_o, 2'd0);
    check("arst_conv", conv_start_o, 1'b0);
    for (int c = 0; c < 4; c++) begin
      m_ticks[c] = 12'd0;
      m_dac[c]   = 6'd0;
    end
    m_err = 4'b0000;
    sel_q.delete();
    sb_q.delete();
    repeat (2) @(negedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i); #1;

    run_scan(4'b1111, 8'd5, 4'b0000, 1);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("sel_empty", 64'(sel_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
